// File: rtl/mem_exit_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_exit_monitor_if
// Description : SRAM-side memory request bus as seen by the exit monitor.
//               The master modport drives the bus; the slave modport only
//               observes it.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_exit_monitor_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    req_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output be_i,
    output wdata_i
  );

  modport slave (
    input req_i,
    input we_i,
    input addr_i,
    input be_i,
    input wdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_exit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mem_exit_monitor
// Description : Passive snoop of the SRAM bus. Shadows byte-enabled writes to
//               the tohost word and raises a sticky exit (with exit code) or
//               a sticky timeout when the cycle budget expires first.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_exit_monitor #(
  parameter int              ADDR_WIDTH     = 64,
  parameter int              DATA_WIDTH     = 64,
  parameter logic [63:0]     TOHOST_ADDR    = 64'h8000_1000,
  parameter logic [31:0]     TIMEOUT_CYCLES = 32'd0
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  mem_exit_monitor_if.slave  bus,
  output logic               exit_valid_o,
  output logic [31:0]        exit_o,
  output logic               timeout_o,
  output logic [63:0]        tohost_o,
  output logic [31:0]        wr_count_o
);

  localparam int                    c_NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_TOHOST = ADDR_WIDTH'(TOHOST_ADDR);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_EXITED    = 2'd1;
  localparam logic [1:0] S_TIMED_OUT = 2'd2;

  logic [1:0]            r_state;
  logic                  r_hit_q;
  logic [c_NBYTES-1:0]   r_be_q;
  logic [DATA_WIDTH-1:0] r_wdata_q;
  logic [DATA_WIDTH-1:0] r_tohost_q;
  logic [31:0]           r_exit_code;
  logic [31:0]           r_wr_count;
  logic [31:0]           r_cyc_q;

  logic                  w_hit;
  logic                  w_wr;
  logic                  w_run;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_exit;
  logic                  w_timeout;
  logic                  w_unused_addr;

  // The word is 8-byte aligned, so the byte-lane address bits do not matter.
  assign w_hit = bus.req_i & bus.we_i &
                 (bus.addr_i[ADDR_WIDTH-1:3] == c_TOHOST[ADDR_WIDTH-1:3]);
  assign w_wr  = bus.req_i & bus.we_i;
  assign w_run = (r_state == S_RUN);
  assign w_unused_addr = ^bus.addr_i[2:0];

  generate
    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_mask
      assign w_mask[8*gi +: 8] = {8{r_be_q[gi]}};
    end
  endgenerate

  assign w_merged  = (r_tohost_q & ~w_mask) | (r_wdata_q & w_mask);
  assign w_exit    = r_hit_q & r_be_q[0] & w_merged[0];
  // An exit on the same edge takes precedence over the timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 32'd0) &&
                     (r_cyc_q == TIMEOUT_CYCLES - 32'd1) && !w_exit;

  // Stage 1: register the snooped write so the merge works on one-cycle-old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_q   <= 1'b0;
      r_be_q    <= '0;
      r_wdata_q <= '0;
    end else begin
      r_hit_q   <= w_hit;
      r_be_q    <= bus.be_i;
      r_wdata_q <= bus.wdata_i;
    end
  end

  // Stage 2 and run/terminal control: merge into the shadow, count, and latch the outcome.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_RUN;
      r_tohost_q  <= '0;
      r_exit_code <= '0;
      r_wr_count  <= '0;
      r_cyc_q     <= '0;
    end else if (w_run) begin
      if (r_hit_q) begin
        r_tohost_q <= w_merged;
      end
      if (w_exit) begin
        r_state     <= S_EXITED;
        r_exit_code <= w_merged[32:1];
      end else if (w_timeout) begin
        r_state     <= S_TIMED_OUT;
        r_exit_code <= 32'hFFFF_FFFF;
      end
      r_cyc_q <= r_cyc_q + 32'd1;
      if (w_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign exit_valid_o = (r_state == S_EXITED) || (r_state == S_TIMED_OUT);
  assign timeout_o    = (r_state == S_TIMED_OUT);
  assign exit_o       = r_exit_code;
  assign tohost_o     = r_tohost_q[63:0];
  assign wr_count_o   = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_exit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_exit_monitor
// Description : Self-checking bench. Two monitors (no timeout / 100-cycle
//               timeout) watch one shared bus; a behavioural model predicts
//               both every cycle, and directed cases pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_exit_monitor;

  localparam logic [63:0] TOHOST = 64'h8000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_exit_monitor_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  logic        ev0, to0, ev1, to1;
  logic [31:0] ex0, wc0, ex1, wc1;
  logic [63:0] th0, th1;

  mem_exit_monitor #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TOHOST_ADDR(TOHOST),
                     .TIMEOUT_CYCLES(32'd0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .exit_valid_o(ev0), .exit_o(ex0), .timeout_o(to0),
    .tohost_o(th0), .wr_count_o(wc0));

  mem_exit_monitor #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TOHOST_ADDR(TOHOST),
                     .TIMEOUT_CYCLES(32'd100)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .exit_valid_o(ev1), .exit_o(ex1), .timeout_o(to1),
    .tohost_o(th1), .wr_count_o(wc1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned  m_budget [2] = '{0, 100};
  bit           m_valid = 1'b0;
  bit           m_done [2];
  bit           m_to   [2];
  logic [31:0]  m_ex   [2];
  logic [31:0]  m_wc   [2];
  logic [31:0]  m_cyc  [2];
  logic [63:0]  m_th   [2];
  bit           p_hit;
  logic [7:0]   p_be;
  logic [63:0]  p_d;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] be,
                                        input logic [63:0] d);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_step();
    bit          hit_now, wr_now;
    logic [63:0] mg;
    hit_now = bus.req_i && bus.we_i && ((bus.addr_i >> 3) == (TOHOST >> 3));
    wr_now  = bus.req_i && bus.we_i;
    if (rst) begin
      m_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0; m_to[i] = 0; m_ex[i] = 0; m_wc[i] = 0; m_cyc[i] = 0; m_th[i] = 0;
      end
      p_hit = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_done[i]) begin
          if (p_hit) begin
            mg = merge(m_th[i], p_be, p_d);
            m_th[i] = mg;
            if (p_be[0] && mg[0]) begin
              m_done[i] = 1;
              m_ex[i]   = mg[32:1];
            end
          end
          if (!m_done[i] && m_budget[i] != 0 && m_cyc[i] == m_budget[i] - 1) begin
            m_done[i] = 1;
            m_to[i]   = 1;
            m_ex[i]   = 32'hFFFF_FFFF;
          end
          m_cyc[i]++;
          if (wr_now && m_wc[i] != 32'hFFFF_FFFF) m_wc[i]++;
        end
      end
      p_hit = hit_now;
    end
    p_be = bus.be_i;
    p_d  = bus.wdata_i;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (m_valid) begin
        check("m0_ev", 64'(ev0), 64'(m_done[0]));
        check("m0_to", 64'(to0), 64'(m_to[0]));
        check("m0_ex", 64'(ex0), 64'(m_ex[0]));
        check("m0_th", th0, m_th[0]);
        check("m0_wc", 64'(wc0), 64'(m_wc[0]));
        check("m1_ev", 64'(ev1), 64'(m_done[1]));
        check("m1_to", 64'(to1), 64'(m_to[1]));
        check("m1_ex", 64'(ex1), 64'(m_ex[1]));
        check("m1_th", th1, m_th[1]);
        check("m1_wc", 64'(wc1), 64'(m_wc[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit rq, input bit w, input logic [63:0] a,
                       input logic [7:0] b, input logic [63:0] d);
    @(negedge clk);
    rst         = r;
    bus.req_i   = rq;
    bus.we_i    = w;
    bus.addr_i  = a;
    bus.be_i    = b;
    bus.wdata_i = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 64'h0, 8'h0, 64'h0);
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] b, input logic [63:0] d);
    drive(0, 1, 1, a, b, d);
  endtask

  // Assert reset for n cycles, then release; returns in cycle 0 of the run.
  task automatic reset_dut(input int n);
    repeat (n) drive(1, 0, 0, 64'h0, 8'h0, 64'h0);
    idle(1);
  endtask

  initial begin
    logic [63:0] a, d;
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;

    // Reset values
    reset_dut(3);
    check("rst_ev0", 64'(ev0), 64'd0); check("rst_to0", 64'(to0), 64'd0);
    check("rst_ex0", 64'(ex0), 64'd0); check("rst_th0", th0, 64'd0);
    check("rst_wc0", 64'(wc0), 64'd0);
    check("rst_ev1", 64'(ev1), 64'd0); check("rst_th1", th1, 64'd0);

    // Timeout at exactly cycle 100; no-timeout instance stays quiet for 1000 cycles
    idle(99);
    check("to_c99_ev1", 64'(ev1), 64'd0);
    idle(1);
    check("to_c100_ev1", 64'(ev1), 64'd1);
    check("to_c100_to1", 64'(to1), 64'd1);
    check("to_c100_ex1", 64'(ex1), 64'hFFFF_FFFF);
    idle(900);
    check("idle1000_ev0", 64'(ev0), 64'd0);
    wr(TOHOST, 8'hFF, 64'h1);
    idle(2);
    check("exit1_ev0", 64'(ev0), 64'd1);
    check("exit1_ex0", 64'(ex0), 64'd0);
    check("exit1_th0", th0, 64'h1);
    check("late_th1", th1, 64'h0);
    check("late_ex1", 64'(ex1), 64'hFFFF_FFFF);

    // Exit code 0x2A from 0x55
    reset_dut(1);
    wr(TOHOST, 8'hFF, 64'h55);
    idle(1);
    check("exit55_c1_ev0", 64'(ev0), 64'd0);
    idle(1);
    check("exit55_ex0", 64'(ex0), 64'h2A);
    check("exit55_ev1", 64'(ev1), 64'd1);

    // Split write
    reset_dut(1);
    wr(TOHOST + 64'd4, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    idle(2);
    check("split_hi_ev0", 64'(ev0), 64'd0);
    check("split_hi_th0", th0, 64'hDEAD_BEEF_0000_0000);
    wr(TOHOST, 8'h01, 64'h0000_0000_0000_0007);
    idle(2);
    check("split_ev0", 64'(ev0), 64'd1);
    check("split_ex0", 64'(ex0), 64'h8000_0003);

    // Non-matching traffic
    reset_dut(1);
    wr(TOHOST + 64'd8, 8'hFF, 64'h1);
    drive(0, 1, 0, TOHOST, 8'hFF, 64'h1);
    wr(TOHOST, 8'hFE, 64'h1);
    wr(64'h2000, 8'hFF, 64'h1);
    wr(64'h3000, 8'hFF, 64'h1);
    wr(TOHOST + 64'h10, 8'hFF, 64'h1);
    idle(2);
    check("nm_ev0", 64'(ev0), 64'd0);
    check("nm_wc0", 64'(wc0), 64'd5);
    check("nm_th0", th0, 64'h0);

    // Exit on the timeout edge wins
    reset_dut(1);
    idle(97);
    wr(TOHOST, 8'hFF, 64'h9);
    idle(2);
    check("race_ev1", 64'(ev1), 64'd1);
    check("race_to1", 64'(to1), 64'd0);
    check("race_ex1", 64'(ex1), 64'h4);

    // Hit still in stage 1 when the budget expires is discarded
    reset_dut(1);
    idle(98);
    wr(TOHOST, 8'hFF, 64'h3);
    idle(2);
    check("last_to1", 64'(to1), 64'd1);
    check("last_th1", th1, 64'h0);
    check("last_ex1", 64'(ex1), 64'hFFFF_FFFF);
    check("last_ex0", 64'(ex0), 64'h1);

    // One-cycle reset after exit
    drive(1, 0, 0, 64'h0, 8'h0, 64'h0);
    idle(1);
    check("rst1_ev0", 64'(ev0), 64'd0); check("rst1_ex0", 64'(ex0), 64'd0);
    check("rst1_th0", th0, 64'd0);      check("rst1_to1", 64'(to1), 64'd0);

    // Randomized traffic
    for (int round = 0; round < 6; round++) begin
      reset_dut(1 + int'($urandom_range(0, 2)));
      for (int k = 0; k < 250; k++) begin
        case ($urandom_range(0, 3))
          0: a = TOHOST | 64'($urandom_range(0, 7));
          1: a = TOHOST + 64'd8;
          2: a = {$urandom, $urandom};
          default: a = TOHOST;
        endcase
        d = {$urandom, $urandom};
        d[0] = ($urandom_range(0, 15) == 0);
        drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), a, 8'($urandom), d);
      end
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
